// File: rtl/mnist_infer_sequencer.sv
// mnist_infer_sequencer
//
// Holds one image frame in a local buffer, then runs one inference on the
// attached core. The sequence is: wait for the core's weights to load, stream
// every pixel in address order, and collect the class scores while keeping
// a running signed argmax.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   wr_en/addr/data     frame buffer write port (honoured only while idle)
//   start               one-cycle request to run an inference (idle only)
//   core_ready          core has finished loading weights
//   pix_valid/pix_data  pixel stream to the core (data forced to 0 when idle)
//   res_valid/res_data  signed class scores from the core, one per strobe
//   busy, done          busy outside IDLE; done pulses for one cycle per run
//   pred_class/score    argmax index and value of the scores collected
//   err                 0 ok, 1 warmup timeout, 2 collect timeout
//   dbg_state_o         current FSM state, for debug and checkers
//
// Handshake: pix_valid and res_valid are plain strobes with no back-pressure.
// A beat transfers on every rising edge where its valid is high.
// The core must accept one pixel per cycle, and a score is taken on each
// cycle where res_valid is high.
module mnist_infer_sequencer #(
  parameter int IMG_PIXELS = 784,
  parameter int DATA_WIDTH = 8,
  parameter int OUT_COUNT  = 10,
  parameter int RES_WIDTH  = 32,
  parameter int MAX_WARMUP = 200000,
  parameter int MAX_WAIT   = 5000000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [$clog2(IMG_PIXELS)-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  input  logic                          start,
  input  logic                          core_ready,
  output logic                          pix_valid,
  output logic [DATA_WIDTH-1:0]         pix_data,
  input  logic                          res_valid,
  input  logic [RES_WIDTH-1:0]          res_data,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(OUT_COUNT)-1:0]  pred_class,
  output logic [RES_WIDTH-1:0]          pred_score,
  output logic [1:0]                    err,
  output logic [2:0]                    dbg_state_o
);

  localparam int AW = $clog2(IMG_PIXELS);
  localparam int PW = $clog2(IMG_PIXELS + 1);
  localparam int WW = $clog2(MAX_WARMUP + 1);
  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam int KW = $clog2(OUT_COUNT + 1);
  localparam int OW = $clog2(OUT_COUNT);

  localparam logic [AW:0]   PIX_N     = (AW + 1)'(IMG_PIXELS);
  localparam logic [PW-1:0] PIX_LAST  = PW'(IMG_PIXELS - 1);
  localparam logic [WW-1:0] WARM_MAX  = WW'(MAX_WARMUP);
  localparam logic [CW-1:0] WAIT_MAX  = CW'(MAX_WAIT);
  localparam logic [KW-1:0] K_ALL     = KW'(OUT_COUNT);
  localparam logic [KW-1:0] K_LAST    = KW'(OUT_COUNT - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WARMUP  = 3'd1,
    ST_STREAM  = 3'd2,
    ST_COLLECT = 3'd3,
    ST_FINISH  = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [WW-1:0]          warm_q, warm_d;
  logic [CW-1:0]          wait_q, wait_d;
  logic [PW-1:0]          rd_q, rd_d;
  logic [KW-1:0]          k_q, k_d;
  logic [RES_WIDTH-1:0]   max_q, max_d;
  logic [OW-1:0]          cls_q, cls_d;
  logic [1:0]             err_q, err_d;
  logic                   pix_valid_q;
  logic [DATA_WIDTH-1:0]  pix_data_q;
  logic                   issue;
  logic                   accept;

  logic [DATA_WIDTH-1:0]  frame_mem [IMG_PIXELS];

  // Frame buffer: not reset, written only while idle.
  always_ff @(posedge clk) begin
    if (state_q == ST_IDLE && wr_en && ({1'b0, wr_addr} < PIX_N)) begin
      frame_mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    state_d = state_q;
    warm_d  = warm_q;
    wait_d  = wait_q;
    rd_d    = rd_q;
    k_d     = k_q;
    max_d   = max_q;
    cls_d   = cls_q;
    err_d   = err_q;
    issue   = 1'b0;

    // Scores count while streaming or collecting, until all have arrived.
    accept = res_valid && (state_q == ST_STREAM || state_q == ST_COLLECT) &&
             (k_q != K_ALL);
    if (accept) begin
      k_d = k_q + 1'b1;
      // Strictly-greater keeps the lower index on ties; score 0 always seeds.
      if (k_q == '0 || $signed(res_data) > $signed(max_q)) begin
        max_d = res_data;
        cls_d = k_q[OW-1:0];
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_WARMUP;
          warm_d  = '0;
          wait_d  = '0;
          rd_d    = '0;
          k_d     = '0;
          max_d   = '0;
          cls_d   = '0;
          err_d   = 2'd0;
        end
      end
      ST_WARMUP: begin
        if (core_ready) begin
          state_d = ST_STREAM;
        end else begin
          warm_d = warm_q + 1'b1;
          if (warm_d == WARM_MAX) begin
            state_d = ST_FINISH;
            err_d   = 2'd1;
          end
        end
      end
      ST_STREAM: begin
        // One buffer read per cycle; the pixel appears on the next cycle.
        issue = 1'b1;
        if (rd_q == PIX_LAST) begin
          state_d = ST_COLLECT;
          wait_d  = '0;
        end else begin
          rd_d = rd_q + 1'b1;
        end
      end
      ST_COLLECT: begin
        if (k_q == K_ALL || (accept && k_q == K_LAST)) begin
          state_d = ST_FINISH;
          err_d   = 2'd0;
        end else begin
          wait_d = wait_q + 1'b1;
          if (wait_d == WAIT_MAX) begin
            state_d = ST_FINISH;
            err_d   = 2'd2;
          end
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      warm_q      <= '0;
      wait_q      <= '0;
      rd_q        <= '0;
      k_q         <= '0;
      max_q       <= '0;
      cls_q       <= '0;
      err_q       <= 2'd0;
      pix_valid_q <= 1'b0;
      pix_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      warm_q      <= warm_d;
      wait_q      <= wait_d;
      rd_q        <= rd_d;
      k_q         <= k_d;
      max_q       <= max_d;
      cls_q       <= cls_d;
      err_q       <= err_d;
      pix_valid_q <= issue;
      pix_data_q  <= issue ? frame_mem[rd_q[AW-1:0]] : '0;
    end
  end

  assign pix_valid   = pix_valid_q;
  assign pix_data    = pix_data_q;
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_FINISH);
  assign pred_class  = cls_q;
  assign pred_score  = max_q;
  assign err         = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mnist_infer_sequencer.sv
module tb_mnist_infer_sequencer;

  localparam int IMG = 784;
  localparam int DW  = 8;
  localparam int OC  = 10;
  localparam int RW  = 32;
  localparam int MWU = 100;
  localparam int MWT = 1000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic                  wr_en = 1'b0;
  logic [9:0]            wr_addr = '0;
  logic [DW-1:0]         wr_data = '0;
  logic                  start = 1'b0;
  logic                  core_ready = 1'b0;
  logic                  pix_valid;
  logic [DW-1:0]         pix_data;
  logic                  res_valid = 1'b0;
  logic [RW-1:0]         res_data = '0;
  logic                  busy;
  logic                  done;
  logic [3:0]            pred_class;
  logic [RW-1:0]         pred_score;
  logic [1:0]            err;
  logic [2:0]            dbg_state;

  mnist_infer_sequencer #(
    .IMG_PIXELS(IMG), .DATA_WIDTH(DW), .OUT_COUNT(OC), .RES_WIDTH(RW),
    .MAX_WARMUP(MWU), .MAX_WAIT(MWT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .core_ready(core_ready),
    .pix_valid(pix_valid), .pix_data(pix_data),
    .res_valid(res_valid), .res_data(res_data),
    .busy(busy), .done(done), .pred_class(pred_class), .pred_score(pred_score),
    .err(err), .dbg_state_o(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  logic [DW-1:0]        model_mem [IMG];
  logic [DW-1:0]        exp_q [$];
  logic signed [RW-1:0] scores [OC];

  int pix_cnt   = 0;
  int first_cyc = 0;
  int last_cyc  = 0;
  int done_cnt  = 0;
  int done_cyc  = 0;

  // Pixel and done monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (pix_valid) begin
        if (pix_cnt == 0) first_cyc = cyc;
        last_cyc = cyc;
        pix_cnt++;
        if (exp_q.size() == 0) check_eq("pix_extra", 32'd1, 32'd0);
        else check_eq("pix_data", {24'd0, pix_data}, {24'd0, exp_q.pop_front()});
      end else begin
        check_eq("pix_zero", {24'd0, pix_data}, 32'd0);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_px(input int addr, input logic [DW-1:0] data);
    tick();
    wr_en = 1'b1;
    wr_addr = 10'(addr);
    wr_data = data;
    if (addr < IMG) model_mem[addr] = data;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic load_frame(input bit ramp);
    for (int i = 0; i < IMG; i++)
      write_px(i, ramp ? DW'((3 * i) & 8'hFF) : DW'($urandom_range(0, 255)));
    // Out-of-range writes must not disturb anything.
    for (int i = 0; i < 4; i++)
      write_px($urandom_range(IMG, 1023), DW'($urandom_range(0, 255)));
  endtask

  task automatic disturb_cycle();
    wr_en   = ($urandom_range(0, 1) == 1);
    wr_addr = 10'($urandom_range(0, IMG - 1));
    wr_data = DW'($urandom_range(0, 255));
    start   = ($urandom_range(0, 3) == 0);
  endtask

  task automatic run_case(input int ready_dly, input bit warm_to, input int nsc, input bit disturb);
    logic signed [RW-1:0] mx;
    logic [31:0] e_cls, e_sc, e_err;
    int s_cyc, r_cyc, d0;

    // Reference: max value over collected scores, then its first position.
    e_cls = 0; e_sc = 0; e_err = 0;
    if (warm_to) begin
      e_err = 1;
    end else begin
      e_err = (nsc == OC) ? 0 : 2;
      if (nsc > 0) begin
        mx = scores[0];
        for (int i = 1; i < nsc; i++) if (scores[i] > mx) mx = scores[i];
        e_sc = mx;
        for (int i = nsc - 1; i >= 0; i--) if (scores[i] == mx) e_cls = i;
      end
    end

    exp_q.delete();
    if (!warm_to) for (int i = 0; i < IMG; i++) exp_q.push_back(model_mem[i]);
    pix_cnt = 0;
    d0 = done_cnt;

    tick();
    start = 1'b1;
    s_cyc = cyc;
    tick();
    start = 1'b0;
    @(negedge clk);
    check_eq("start_busy", {31'd0, busy}, 32'd1);
    check_eq("start_clr_err", {30'd0, err}, 32'd0);
    check_eq("start_clr_cls", {28'd0, pred_class}, 32'd0);
    check_eq("start_clr_score", pred_score, 32'd0);

    if (warm_to) begin
      for (int t = 0; t < MWU + 50 && done_cnt == d0; t++) begin
        @(negedge clk);
        if (disturb) disturb_cycle();
      end
      wr_en = 1'b0; start = 1'b0;
      check_eq("warm_done_time", 32'(done_cyc - s_cyc), 32'(MWU + 1));
    end else begin
      for (int j = 0; j < ready_dly; j++) begin
        tick();
        if (disturb) disturb_cycle();
      end
      tick();
      wr_en = 1'b0; start = 1'b0;
      core_ready = 1'b1;
      r_cyc = cyc;
      for (int t = 0; t < 3000 && pix_cnt < IMG; t++) begin
        @(negedge clk);
        if (disturb && pix_cnt > 100 && pix_cnt < 120) disturb_cycle();
        else begin wr_en = 1'b0; start = 1'b0; end
      end
      wr_en = 1'b0; start = 1'b0;
      check_eq("pix_count", 32'(pix_cnt), 32'(IMG));
      check_eq("pix_gapfree", 32'(last_cyc - first_cyc), 32'(IMG - 1));
      check_eq("pix_first_lat", {31'd0, (first_cyc - r_cyc) <= 3}, 32'd1);
      for (int i = 0; i < nsc; i++) begin
        repeat ($urandom_range(0, 3)) tick();
        tick();
        res_valid = 1'b1;
        res_data  = scores[i];
        tick();
        res_valid = 1'b0;
      end
      for (int t = 0; t < MWT + 200 && done_cnt == d0; t++) @(negedge clk);
    end
    core_ready = 1'b0;

    check_eq("done_seen", 32'(done_cnt - d0), 32'd1);
    // Scores after the run must not touch the held result.
    tick();
    res_valid = 1'b1;
    res_data  = 32'h7FFF_FFFF;
    tick();
    res_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("done_single", 32'(done_cnt - d0), 32'd1);
    check_eq("idle_busy", {31'd0, busy}, 32'd0);
    check_eq("err", {30'd0, err}, e_err);
    check_eq("pred_class", {28'd0, pred_class}, e_cls);
    check_eq("pred_score", pred_score, e_sc);
    if (warm_to) check_eq("warm_no_pix", 32'(pix_cnt), 32'd0);
  endtask

  task automatic mid_reset();
    int d0;
    exp_q.delete();
    for (int i = 0; i < IMG; i++) exp_q.push_back(model_mem[i]);
    pix_cnt = 0;
    d0 = done_cnt;
    tick(); start = 1'b1;
    tick(); start = 1'b0;
    repeat (5) tick();
    core_ready = 1'b1;
    for (int t = 0; t < 2000 && pix_cnt < 300; t++) @(negedge clk);
    check_eq("rst_reach_300", {31'd0, pix_cnt >= 300}, 32'd1);
    tick();
    rst_n = 1'b0;
    #1;
    check_eq("rst_pix_valid", {31'd0, pix_valid}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    core_ready = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("rst_no_done", 32'(done_cnt - d0), 32'd0);
    check_eq("rst_idle", {29'd0, dbg_state}, 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_busy", {31'd0, busy}, 32'd0);
    check_eq("reset_done", {31'd0, done}, 32'd0);
    check_eq("reset_pix_valid", {31'd0, pix_valid}, 32'd0);
    check_eq("reset_pix_data", {24'd0, pix_data}, 32'd0);
    check_eq("reset_cls", {28'd0, pred_class}, 32'd0);
    check_eq("reset_score", pred_score, 32'd0);
    check_eq("reset_err", {30'd0, err}, 32'd0);
    tick();
    rst_n = 1'b1;

    // Ramp frame with the reference score set; stray writes/starts while busy.
    load_frame(1'b1);
    scores[0] = 5;  scores[1] = -3; scores[2] = 90; scores[3] = 90; scores[4] = 7;
    scores[5] = 0;  scores[6] = 1;  scores[7] = 2;  scores[8] = 3;  scores[9] = 4;
    run_case(50, 1'b0, OC, 1'b1);

    // All-negative ascending scores.
    for (int i = 0; i < OC; i++) scores[i] = -100 + i;
    run_case(10, 1'b0, OC, 1'b0);

    // Core never ready.
    run_case(0, 1'b1, 0, 1'b1);

    // Only four scores arrive.
    for (int i = 0; i < OC; i++) scores[i] = $signed(32'($urandom_range(0, 200))) - 100;
    run_case(20, 1'b0, 4, 1'b0);

    // No scores at all.
    run_case(3, 1'b0, 0, 1'b0);

    // Reset in the middle of streaming, then a clean rerun.
    mid_reset();
    for (int i = 0; i < OC; i++) scores[i] = $signed(32'($urandom_range(0, 40))) - 20;
    run_case(15, 1'b0, OC, 1'b0);

    // Random frames and small-range scores so ties are common.
    for (int r = 0; r < 3; r++) begin
      load_frame(1'b0);
      for (int i = 0; i < OC; i++) scores[i] = $signed(32'($urandom_range(0, 8))) - 4;
      run_case($urandom_range(0, 80), 1'b0, OC, r[0]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the bench always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
